// File: rtl/logistic_iter_if.sv
// Output stream of the logistic-map iterator: iterate value with a valid/ready handshake.
interface logistic_iter_if #(
  parameter int XW = 16
);
  logic [XW-1:0] x_out;
  logic          x_valid;
  logic          x_ready;

  modport master (
    output x_out,
    output x_valid,
    input  x_ready
  );

  modport slave (
    input  x_out,
    input  x_valid,
    output x_ready
  );
endinterface

// File: rtl/logistic_iter.sv
// Fixed-point logistic map x <= mu*x*(1-x), one iterate per calc_tick, streamed out over a valid/ready handshake.
// Optional macro CHAOS_FIXPT_EN: end a run early when an iterate repeats the previous x.
//
// state | meaning
// IDLE  | waiting for start; holds results of the last run
// MUL1  | waiting for calc_tick, then forms p1 = x*(1-x)
// MUL2  | forms the next iterate x = mu*p1
// OUT   | presents x_out until the consumer takes it
module logistic_iter #(
  parameter int XW  = 16,
  parameter int MUW = 18
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [MUW-1:0]   mu,
  input  logic [8:0]       maxrepeat,
  input  logic [XW-1:0]    x0,
  input  logic             calc_tick,
  input  logic             abort,
  logistic_iter_if.master  x_if,
  output logic             busy,
  output logic             done,
  output logic [8:0]       iter
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL1 = 2'd1,
    S_MUL2 = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_done_set;
  logic             w_xfer;
  logic             w_fix;
  logic             w_accept;

  logic [MUW-1:0]   r_mu;
  logic [8:0]       r_maxrep;
  logic [XW-1:0]    r_x;
  logic [XW-1:0]    r_p1;
  logic [8:0]       r_iter;
  logic             r_done;

  logic [XW-1:0]    w_xc;
  logic [XW-1:0]    w_p1;
  logic [XW-1:0]    w_x_next;
  logic [8:0]       w_iter_inc;

  // Operands are zero-extended so the full product is kept before the shift.
  assign w_xc       = {XW{1'b1}} - r_x;
  assign w_p1       = XW'(({{XW{1'b0}}, r_x} * {{XW{1'b0}}, w_xc}) >> XW);
  assign w_x_next   = XW'(({{XW{1'b0}}, r_mu} * {{MUW{1'b0}}, r_p1}) >> (MUW - 2));
  assign w_iter_inc = r_iter + 9'd1;
  assign w_accept   = (r_state == S_IDLE) && start;

`ifdef CHAOS_FIXPT_EN
  logic [XW-1:0] r_x_prev;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_x_prev <= '0;
    end else if (r_state == S_MUL2 && !abort) begin
      r_x_prev <= r_x;
    end
  end

  assign w_fix = (r_x == r_x_prev);
`else
  assign w_fix = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_done_set = 1'b0;
    w_xfer     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (maxrepeat == 9'd0) begin
            w_done_set = 1'b1;
          end else begin
            w_next = S_MUL1;
          end
        end
      end
      S_MUL1: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (calc_tick) begin
          w_next = S_MUL2;
        end
      end
      S_MUL2: begin
        if (abort) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_OUT;
        end
      end
      S_OUT: begin
        // Abort wins over a transfer offered on the same cycle.
        if (abort) begin
          w_next = S_IDLE;
        end else if (x_if.x_ready) begin
          w_xfer = 1'b1;
          if (w_iter_inc == r_maxrep || w_fix) begin
            w_done_set = 1'b1;
            w_next     = S_IDLE;
          end else begin
            w_next = S_MUL1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    x_if.x_valid = (r_state == S_OUT);
    busy         = (r_state != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_mu     <= '0;
      r_maxrep <= '0;
      r_x      <= '0;
      r_p1     <= '0;
      r_iter   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_done_set;
      if (w_accept) begin
        r_mu     <= mu;
        r_maxrep <= maxrepeat;
        r_x      <= x0;
        r_iter   <= '0;
      end
      if (r_state == S_MUL1 && !abort && calc_tick) begin
        r_p1 <= w_p1;
      end
      if (r_state == S_MUL2 && !abort) begin
        r_x <= w_x_next;
      end
      if (w_xfer) begin
        r_iter <= w_iter_inc;
      end
    end
  end

  assign x_if.x_out = r_x;
  assign done       = r_done;
  assign iter       = r_iter;

endmodule

// File: tb/tb_logistic_iter.sv
// Directed bench for logistic_iter: single-iterate vector table plus long-run, abort, reset and fixed-point sequences.
module tb_logistic_iter;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [17:0] mu;
  logic [8:0]  maxrepeat;
  logic [15:0] x0;
  logic        calc_tick;
  logic        abort;
  logic        busy;
  logic        done;
  logic [8:0]  iter;

  int n_tests;
  int n_fail;

  logistic_iter_if #(.XW(16)) s_if ();

  logistic_iter #(.XW(16), .MUW(18)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .mu        (mu),
    .maxrepeat (maxrepeat),
    .x0        (x0),
    .calc_tick (calc_tick),
    .abort     (abort),
    .x_if      (s_if.master),
    .busy      (busy),
    .done      (done),
    .iter      (iter)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [17:0] mu;
    logic [15:0] x0;
    logic [15:0] exp_x;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [17:0] m, input logic [15:0] x);
    logic [63:0] p1;
    logic [63:0] r;
    p1 = ({48'd0, x} * {48'd0, 16'hFFFF - x}) >> 16;
    r  = ({46'd0, m} * p1) >> 16;
    return r[15:0];
  endfunction

  // Runs one start..done sequence; all decisions are made on falling edges.
  task automatic run(input logic [17:0] m, input logic [15:0] xi, input logic [8:0] n,
                     input bit rnd_ready, input int budget,
                     output int xfers, output logic [15:0] last_x, output bit done_seen);
    logic [15:0] model_x;
    logic [15:0] prev_x;
    bit          prev_stall;
    @(negedge CLK);
    start = 1'b1; mu = m; x0 = xi; maxrepeat = n; calc_tick = 1'b0; s_if.x_ready = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    model_x = xi; xfers = 0; done_seen = 1'b0; prev_stall = 1'b0; prev_x = '0; last_x = '0;
    for (int c = 0; c < budget && !done_seen; c++) begin
      calc_tick     = 1'($urandom_range(0, 1));
      s_if.x_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) check("x_out_stable", {s_if.x_valid, s_if.x_out}, {1'b1, prev_x});
      if (s_if.x_valid && s_if.x_ready) begin
        model_x = step(m, model_x);
        check("x_out_model", s_if.x_out, model_x);
        xfers++;
        last_x = s_if.x_out;
      end
      prev_stall = s_if.x_valid && !s_if.x_ready;
      prev_x     = s_if.x_out;
      @(negedge CLK);
      if (done) done_seen = 1'b1;
    end
    calc_tick = 1'b0;
    s_if.x_ready = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int c;
    c = 0;
    calc_tick = 1'b1;
    while (!s_if.x_valid && c < budget) begin
      @(negedge CLK);
      c++;
    end
    calc_tick = 1'b0;
    if (!s_if.x_valid) check("wait_valid_timeout", 0, 1);
  endtask

  initial begin
    int          xfers;
    logic [15:0] last_x;
    bit          done_seen;
    int          exp_n;

    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{mu: 18'h2DBDF, x0: 16'h8000, exp_x: 16'hB6F4};
    vecs[1] = '{mu: 18'h10000, x0: 16'h8000, exp_x: 16'h3FFF};
    vecs[2] = '{mu: 18'h3FFFF, x0: 16'h8000, exp_x: 16'hFFFB};
    vecs[3] = '{mu: 18'h20000, x0: 16'h4000, exp_x: 16'h5FFE};
    vecs[4] = '{mu: 18'h30000, x0: 16'hC000, exp_x: 16'h8FFD};
    vecs[5] = '{mu: 18'h30000, x0: 16'hFFFF, exp_x: 16'h0000};

    RST = 1'b0; start = 1'b0; mu = '0; maxrepeat = '0; x0 = '0;
    calc_tick = 1'b0; abort = 1'b0; s_if.x_ready = 1'b0;
    #12;
    check("reset_outputs", {s_if.x_out, s_if.x_valid, busy, done, iter}, '0);
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run(vecs[i].mu, vecs[i].x0, 9'd1, 1'b0, 50, xfers, last_x, done_seen);
      check($sformatf("vec%0d_xfers", i), xfers, 1);
      check($sformatf("vec%0d_x_out", i), last_x, vecs[i].exp_x);
      check($sformatf("vec%0d_done", i), done_seen, 1);
      check($sformatf("vec%0d_iter", i), iter, 1);
      @(negedge CLK);
      check($sformatf("vec%0d_done_pulse", i), {done, busy}, 2'b00);
    end

    // maxrepeat=0: immediate done, never busy.
    @(negedge CLK);
    start = 1'b1; maxrepeat = 9'd0; mu = 18'h2DBDF; x0 = 16'h1111;
    @(negedge CLK);
    start = 1'b0;
    check("zero_rep_done", {done, busy, s_if.x_valid, iter}, {1'b1, 1'b0, 1'b0, 9'd0});
    @(negedge CLK);
    check("zero_rep_after", {done, busy, s_if.x_valid}, 3'b000);

    // Long run with a randomly stalling consumer.
    run(18'h3DBDF, 16'h1234, 9'd256, 1'b1, 6000, xfers, last_x, done_seen);
    check("long_xfers", xfers, 256);
    check("long_done", done_seen, 1);

    // Zero initial value is a fixed point of the map.
    run(18'h30000, 16'h0000, 9'd5, 1'b0, 200, xfers, last_x, done_seen);
`ifdef CHAOS_FIXPT_EN
    exp_n = 1;
`else
    exp_n = 5;
`endif
    check("fixpt_xfers", xfers, exp_n);
    check("fixpt_x_out", last_x, 16'h0000);
    check("fixpt_done", done_seen, 1);

    // Abort in OUT with x_ready high on the same cycle, during the second iterate.
    @(negedge CLK);
    start = 1'b1; mu = 18'h2DBDF; x0 = 16'h8000; maxrepeat = 9'd3;
    @(negedge CLK);
    start = 1'b0;
    wait_valid(20);
    s_if.x_ready = 1'b1;
    @(negedge CLK);
    s_if.x_ready = 1'b0;
    check("abort_first_iter", iter, 1);
    // Start while busy must not relatch x0.
    start = 1'b1; x0 = 16'h0000;
    @(negedge CLK);
    start = 1'b0;
    wait_valid(20);
    check("busy_start_ignored", s_if.x_out, step(18'h2DBDF, 16'hB6F4));
    abort = 1'b1; s_if.x_ready = 1'b1;
    @(negedge CLK);
    abort = 1'b0; s_if.x_ready = 1'b0;
    check("abort_state", {busy, s_if.x_valid, done, iter}, {3'b000, 9'd1});
    @(negedge CLK);
    check("abort_no_done", {busy, done, iter}, {2'b00, 9'd1});
    run(18'h2DBDF, 16'h8000, 9'd1, 1'b0, 50, xfers, last_x, done_seen);
    check("post_abort_run", {xfers[7:0], last_x, 7'd0, done_seen}, {8'd1, 16'hB6F4, 8'd1});

    // Reset asserted while in MUL2.
    @(negedge CLK);
    start = 1'b1; mu = 18'h2DBDF; x0 = 16'h4321; maxrepeat = 9'd4;
    @(negedge CLK);
    start = 1'b0; calc_tick = 1'b1;
    @(negedge CLK);
    calc_tick = 1'b0;
    check("pre_reset_busy", {busy, s_if.x_out}, {1'b1, 16'h4321});
    #2;
    RST = 1'b0;
    #1;
    check("mid_reset_outputs", {s_if.x_out, s_if.x_valid, busy, done, iter}, '0);
    @(negedge CLK);
    RST = 1'b1;
    run(18'h20000, 16'h4000, 9'd1, 1'b0, 50, xfers, last_x, done_seen);
    check("post_reset_run", {xfers[7:0], last_x, 7'd0, done_seen}, {8'd1, 16'h5FFE, 8'd1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
